uart_frame_tx: RTL and testbench

- UART transmitter producing the 11-bit serial frame consumed by the receive-side frame checker: start(0), 8 data bits LSB first, even parity (parity bit = XOR of data bits), stop(1).
- Accepts a byte through a valid/ready handshake from the user-side logic and serialises it at a fixed baud rate derived from the 50 MHz clk.
- Has per-frame fault-injection inputs so the receiver's parity-error and frame-error paths can be exercised on hardware.

---
 rtl/uart_frame_tx_if.sv | 19 +
 rtl/uart_frame_tx.sv | 139 +++++++++++++
 tb/tb_uart_frame_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Byte-side handshake between user logic and the UART frame transmitter,
// including the per-frame fault-injection strobes that travel with the byte.
interface uart_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       inj_parity_err;
    logic       inj_frame_err;

    modport master (
        output tx_data, tx_valid, inj_parity_err, inj_frame_err,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, inj_parity_err, inj_frame_err,
        output tx_ready
    );
endinterface

// File: rtl/uart_frame_tx.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// Parity and stop bits can be corrupted per frame to exercise receiver error paths.
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              clk,
    input  logic              rst,
    uart_frame_tx_if.slave    ifc,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             stop_q, stop_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic bit_last;
    logic stop_last;
    logic accept;

    assign bit_last  = (cnt_q == CNT_LAST);
    assign stop_last = (state_q == STOP) && bit_last;

    // The final stop cycle doubles as an acceptance slot so frames can run back to back.
    assign ifc.tx_ready = (state_q == IDLE) || stop_last;
    assign accept       = ifc.tx_valid && ifc.tx_ready;

    assign frame_done = stop_last;
    assign tx         = tx_q;
    assign busy       = busy_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (state_q != IDLE) begin
            cnt_d = bit_last ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bit_last) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_d = STOP;
                    tx_d    = stop_q;
                end
            end
            STOP: begin
                if (bit_last) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Injection flags are folded into the latched parity/stop values so they
        // cannot leak into any later frame.
        if (accept) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = 3'd0;
            data_d  = ifc.tx_data;
            par_d   = (^ifc.tx_data) ^ ifc.inj_parity_err;
            stop_d  = ~ifc.inj_frame_err;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the data
    // holding registers are reset too, so nothing stale is ever observable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            par_q   <= 1'b0;
            stop_q  <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: directed scenarios plus random frames
// compared cycle by cycle against an 11-bit frame model.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, frame_done;

    uart_frame_tx_if u_if ();

    uart_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .ifc        (u_if),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ones(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return n;
    endfunction

    // Wire image of a frame, index 0 = start bit, index 10 = stop bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pi, input logic fe);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = ((ones(d) % 2) == 1) ^ pi;
        f[10]   = ~fe;
        return f;
    endfunction

    task automatic idle_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            check("idle_tx", tx, 1'b1);
            check("idle_ready", u_if.tx_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", frame_done, 1'b0);
            @(negedge clk);
        end
    endtask

    // Called at a negedge while tx_ready=1; returns at the negedge of start-bit cycle 0.
    task automatic accept(input logic [7:0] d, input logic pi, input logic fe);
        u_if.tx_data        = d;
        u_if.inj_parity_err = pi;
        u_if.inj_frame_err  = fe;
        u_if.tx_valid       = 1'b1;
        @(negedge clk);
    endtask

    // Checks one whole frame cycle by cycle. With chain set, the next byte is
    // offered throughout so it must be taken on the final stop cycle. With noise
    // set, inputs churn and tx_valid pulses once mid-frame.
    task automatic check_frame(input logic [7:0] d, input logic pi, input logic fe,
                               input logic chain, input logic [7:0] nd,
                               input logic npi, input logic nfe, input logic noise);
        logic [10:0] exp_f;
        logic [10:0] mid;
        logic [7:0]  got;
        exp_f = frame_bits(d, pi, fe);
        mid   = '0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("tx_b%0d_c%0d", b, c), tx, exp_f[b]);
                check("frame_busy", busy, 1'b1);
                check($sformatf("ready_b%0d_c%0d", b, c), u_if.tx_ready, (b == 10 && c == CPB - 1));
                check($sformatf("done_b%0d_c%0d", b, c), frame_done, (b == 10 && c == CPB - 1));
                if (c == CPB / 2) mid[b] = tx;
                if (chain) begin
                    u_if.tx_data        = nd;
                    u_if.inj_parity_err = npi;
                    u_if.inj_frame_err  = nfe;
                    u_if.tx_valid       = 1'b1;
                end else if (noise) begin
                    u_if.tx_data        = 8'($urandom);
                    u_if.inj_parity_err = 1'($urandom);
                    u_if.inj_frame_err  = 1'($urandom);
                    u_if.tx_valid       = (b == 5 && c == 1);
                end else begin
                    u_if.tx_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        u_if.tx_valid = 1'b0;
        got = mid[8:1];
        check("decoded_byte", got, d);
        check("decoded_perr", ((ones(got) + int'(mid[9])) % 2) == 1, pi);
        check("decoded_ferr", !mid[10], fe);
    endtask

    initial begin
        logic [7:0] d, nd;
        logic       pi, fe, npi, nfe, chain;

        rst                 = 1'b0;
        u_if.tx_data        = 8'h00;
        u_if.tx_valid       = 1'b0;
        u_if.inj_parity_err = 1'b0;
        u_if.inj_frame_err  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", u_if.tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        idle_check(20);

        accept(8'hA5, 1'b0, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(3);

        accept(8'h07, 1'b0, 1'b0);
        check_frame(8'h07, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(3);

        accept(8'h3C, 1'b1, 1'b0);
        check_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(2);
        accept(8'h3C, 1'b0, 1'b1);
        check_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(2);
        accept(8'h3C, 1'b0, 1'b0);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(2);

        // Reset in the middle of data bit 3 (wire bit 4).
        accept(8'hC3, 1'b0, 1'b0);
        u_if.tx_valid = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("pre_rst_tx", tx, 1'b0);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_done", frame_done, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", u_if.tx_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle_check(2 * 11 * CPB);

        accept(8'h55, 1'b0, 1'b0);
        check_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check(2);

        accept(8'h96, 1'b0, 1'b0);
        check_frame(8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle_check(12 * CPB);

        d  = 8'($urandom);
        pi = 1'($urandom);
        fe = 1'($urandom);
        accept(d, pi, fe);
        for (int i = 0; i < 12; i++) begin
            chain = (i < 11) && ($urandom_range(0, 1) == 1);
            nd    = 8'($urandom);
            npi   = ($urandom_range(0, 3) == 0);
            nfe   = ($urandom_range(0, 3) == 0);
            check_frame(d, pi, fe, chain, nd, npi, nfe, 1'b0);
            if (!chain) begin
                idle_check(2);
                if (i < 11) accept(nd, npi, nfe);
            end
            d  = nd;
            pi = npi;
            fe = nfe;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
